armleocpu_ptw: RTL and testbench
================================

# armleocpu_ptw

Sv32 hardware page-table walker for the cache's address-translation path. On a TLB miss it walks the two-level page table in memory and returns a leaf PPN plus an 8-bit access tag, or a pagefault or accessfault. The returned tag has the same bit layout the cache's pagefault checker consumes: V, R, W, X, U, G, A, D in bits 0..7. The cache then writes the result into its TLB. The walker never sets A or D; missing A/D bits surface later as pagefaults in the checker.

## Interface
- No parameters (Sv32 fixed: 2 levels, 4-byte PTE, 34-bit physical address).
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- resolve_request  in  1  start walk; sampled only in IDLE
- resolve_virtual_address  in  20  VPN (VA[31:12]); captured on accept
- satp_ppn  in  22  root table PPN; captured on accept
- resolve_ack  out  1  one-cycle pulse: request accepted
- resolve_done  out  1  one-cycle pulse: result valid
- resolve_pagefault  out  1  walk ended in page fault
- resolve_accessfault  out  1  memory returned error
- resolve_physical_address  out  22  leaf PPN
- resolve_metadata  out  8  PTE[7:0] of leaf (access tag)
- mem_address  out  34  PTE byte address
- mem_read  out  1  read request; held until accepted
- mem_waitrequest  in  1  high = request not accepted this cycle
- mem_readdatavalid  in  1  read data/response valid
- mem_readdata  in  32  PTE
- mem_response  in  2  0 = OKAY, nonzero = error

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If resolve_request is high: pulse resolve_ack, latch VPN and satp_ppn, set level=1.
  - Load mem_address = {satp_ppn, vpn[19:10], 2'b00}, go to ISSUE.
- ISSUE: mem_read=1 and mem_address stable. On the first cycle with !mem_waitrequest, go to WAIT.
- WAIT: mem_read=0. On mem_readdatavalid:
  - mem_response!=0: accessfault=1, pagefault=0, finish.
  - PTE.V=0, or (PTE.R=0 and PTE.W=1): pagefault, finish.
  - Leaf (PTE.R or PTE.X):
    - level=1 with PTE[19:10]!=0: pagefault (misaligned superpage).
    - level=1 otherwise: PPN = {PTE[31:20], vpn[9:0]}.
    - level=0: PPN = PTE[31:10].
    - metadata = PTE[7:0], finish.
  - Pointer (R=X=0, V=1):
    - level=0: pagefault, finish.
    - level=1: level=0, mem_address = {PTE[31:10], vpn[9:0], 2'b00}, go to ISSUE.
- Finish: pulse resolve_done for one cycle with results registered, return to IDLE.
- On a fault: resolve_physical_address and resolve_metadata hold the faulting PTE fields (don't-care), and exactly one of pagefault/accessfault is 1.
- Result outputs hold their value until the next finish.
- resolve_request while not IDLE is ignored. The requester keeps it high until ack.
- mem_readdatavalid outside WAIT is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, level 1.
- Asynchronous reset mid-walk: mem_read drops immediately and the walk is abandoned. A later stray mem_readdatavalid is ignored.
- ack is in the same cycle request is seen in IDLE. The first mem_read is the next cycle.
- Minimum latency, zero wait states, data on the cycle after accept:
  - Superpage: request→done = 3 cycles.
  - 4 KiB page: 5 cycles.
- resolve_done and resolve_ack are never high in the same cycle.
- Earliest next ack is the cycle after done.

## Test plan
- Superpage: satp_ppn=0x00001, VPN=0x40123. L1 PTE at 0x1400 = 0x200000CF. Expect done, pagefault=0, PPN=0x080123, metadata=0xCF, one memory read.
- 4 KiB page: L1 PTE = 0x00000801 (pointer to PPN 0x2). L0 PTE at 0x2000+vpn[9:0]*4 = 0x12345C7. Expect PPN=0x0048D1, metadata=0xC7, two reads.
- Faults: V=0 at L1 → pagefault. R=0,W=1 → pagefault. Misaligned superpage 0x00000C0F → pagefault. Pointer at L0 → pagefault.
- mem_response=2 on the L0 read → accessfault=1, pagefault=0, done exactly once.
- Hold mem_waitrequest for 5 cycles → mem_read and mem_address stay stable. Latency extends by 5. A request during the walk gets no ack.
- Assert rst while in WAIT, then deliver mem_readdatavalid → no done. All outputs are 0. A new request completes correctly.

Source files
------------

// File: rtl/armleocpu_ptw.sv
// Sv32 page-table walker: resolves a VPN through the two-level table in memory
// and returns the leaf PPN plus its access tag, or a page/access fault.
module armleocpu_ptw (
    input  logic        clk,
    input  logic        rst,
    input  logic        resolve_request,
    input  logic [19:0] resolve_virtual_address,
    input  logic [21:0] satp_ppn,
    output logic        resolve_ack,
    output logic        resolve_done,
    output logic        resolve_pagefault,
    output logic        resolve_accessfault,
    output logic [21:0] resolve_physical_address,
    output logic [7:0]  resolve_metadata,
    output logic [33:0] mem_address,
    output logic        mem_read,
    input  logic        mem_waitrequest,
    input  logic        mem_readdatavalid,
    input  logic [31:0] mem_readdata,
    input  logic [1:0]  mem_response
);

    localparam int unsigned PPN_W = 22;
    localparam int unsigned VPN_W = 20;
    localparam int unsigned PA_W  = 34;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t             state, state_n;
    logic               level, level_n;
    logic [VPN_W-1:0]   vpn, vpn_n;
    logic [PA_W-1:0]    addr_n;
    logic               done_n, pf_n, af_n;
    logic [PPN_W-1:0]   ppn_n;
    logic [7:0]         meta_n;
    logic               walk_fin, walk_pf, walk_af;

    logic pte_v, pte_r, pte_w, pte_x;
    logic unused_rsw;

    assign pte_v = mem_readdata[0];
    assign pte_r = mem_readdata[1];
    assign pte_w = mem_readdata[2];
    assign pte_x = mem_readdata[3];
    assign unused_rsw = ^mem_readdata[9:8];

    // Accept is suppressed on the done cycle so ack and done never coincide.
    assign resolve_ack = (state == IDLE) && resolve_request && !resolve_done;
    assign mem_read    = (state == ISSUE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                    <= IDLE;
            level                    <= 1'b1;
            vpn                      <= '0;
            mem_address              <= '0;
            resolve_done             <= 1'b0;
            resolve_pagefault        <= 1'b0;
            resolve_accessfault      <= 1'b0;
            resolve_physical_address <= '0;
            resolve_metadata         <= '0;
        end else begin
            state                    <= state_n;
            level                    <= level_n;
            vpn                      <= vpn_n;
            mem_address              <= addr_n;
            resolve_done             <= done_n;
            resolve_pagefault        <= pf_n;
            resolve_accessfault      <= af_n;
            resolve_physical_address <= ppn_n;
            resolve_metadata         <= meta_n;
        end
    end

    always_comb begin
        state_n  = state;
        level_n  = level;
        vpn_n    = vpn;
        addr_n   = mem_address;
        done_n   = 1'b0;
        pf_n     = resolve_pagefault;
        af_n     = resolve_accessfault;
        ppn_n    = resolve_physical_address;
        meta_n   = resolve_metadata;
        walk_fin = 1'b0;
        walk_pf  = 1'b0;
        walk_af  = 1'b0;

        case (state)
            IDLE: begin
                if (resolve_ack) begin
                    vpn_n   = resolve_virtual_address;
                    level_n = 1'b1;
                    addr_n  = {satp_ppn, resolve_virtual_address[19:10], 2'b00};
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (!mem_waitrequest) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (mem_readdatavalid) begin
                    walk_fin = 1'b1;
                    if (mem_response != 2'b00) begin
                        walk_af = 1'b1;
                    end else if (!pte_v || (!pte_r && pte_w)) begin
                        walk_pf = 1'b1;
                    end else if (pte_r || pte_x) begin
                        walk_pf = level && (mem_readdata[19:10] != 10'd0);
                    end else if (!level) begin
                        walk_pf = 1'b1;
                    end else begin
                        // Valid pointer at the root level: descend.
                        walk_fin = 1'b0;
                        level_n  = 1'b0;
                        addr_n   = {mem_readdata[31:10], vpn[9:0], 2'b00};
                        state_n  = ISSUE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (walk_fin) begin
            done_n  = 1'b1;
            pf_n    = walk_pf;
            af_n    = walk_af;
            ppn_n   = level ? {mem_readdata[31:20], vpn[9:0]} : mem_readdata[31:10];
            meta_n  = mem_readdata[7:0];
            state_n = IDLE;
        end
    end

endmodule

// File: tb/tb_armleocpu_ptw.sv
// Randomized bench for armleocpu_ptw against a table-walk reference model
// over a sparse memory with a stalling, error-injecting responder.
module tb_armleocpu_ptw;

    logic        clk = 1'b0;
    logic        rst;
    logic        resolve_request;
    logic [19:0] resolve_virtual_address;
    logic [21:0] satp_ppn;
    logic        resolve_ack, resolve_done, resolve_pagefault, resolve_accessfault;
    logic [21:0] resolve_physical_address;
    logic [7:0]  resolve_metadata;
    logic [33:0] mem_address;
    logic        mem_read;
    logic        mem_waitrequest;
    logic        mem_readdatavalid;
    logic [31:0] mem_readdata;
    logic [1:0]  mem_response;

    armleocpu_ptw dut (
        .clk(clk), .rst(rst),
        .resolve_request(resolve_request),
        .resolve_virtual_address(resolve_virtual_address),
        .satp_ppn(satp_ppn),
        .resolve_ack(resolve_ack), .resolve_done(resolve_done),
        .resolve_pagefault(resolve_pagefault), .resolve_accessfault(resolve_accessfault),
        .resolve_physical_address(resolve_physical_address),
        .resolve_metadata(resolve_metadata),
        .mem_address(mem_address), .mem_read(mem_read),
        .mem_waitrequest(mem_waitrequest), .mem_readdatavalid(mem_readdatavalid),
        .mem_readdata(mem_readdata), .mem_response(mem_response)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [logic [33:0]];
    bit          err [logic [33:0]];

    int          stall_req = 0;
    bit          rand_wait = 1'b0;
    bit          hold_valid = 1'b0;
    bit          pend = 1'b0;
    logic [33:0] pend_addr;
    int          reads = 0;
    int          stalls = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: walk the table by address arithmetic, highest level first.
    function automatic void ref_walk(input logic [21:0] satp, input logic [19:0] vpn,
                                     output bit pf, output bit af, output logic [21:0] ppn,
                                     output logic [7:0] meta, output int nrd);
        logic [33:0] a;
        logic [31:0] pte;
        pf = 0; af = 0; ppn = '0; meta = '0; nrd = 0;
        a = {satp, 12'h000} + 34'(vpn[19:10]) * 34'd4;
        for (int lvl = 1; lvl >= 0; lvl--) begin
            nrd++;
            pte = mem.exists(a) ? mem[a] : 32'h0;
            if (err.exists(a)) begin af = 1; return; end
            if (!pte[0] || (!pte[1] && pte[2])) begin pf = 1; return; end
            if (pte[1] || pte[3]) begin
                if (lvl == 1 && pte[19:10] != 10'd0) pf = 1;
                else begin
                    ppn  = (lvl == 1) ? {pte[31:20], vpn[9:0]} : pte[31:10];
                    meta = pte[7:0];
                end
                return;
            end
            if (lvl == 0) begin pf = 1; return; end
            a = 34'(pte[31:10]) * 34'd4096 + 34'(vpn[9:0]) * 34'd4;
        end
    endfunction

    // Memory responder: decides waitrequest each cycle, answers one cycle after accept.
    initial begin
        mem_waitrequest   = 1'b0;
        mem_readdatavalid = 1'b0;
        mem_readdata      = '0;
        mem_response      = '0;
        forever begin
            @(negedge clk);
            mem_readdatavalid = 1'b0;
            mem_response      = 2'b00;
            if (pend && !hold_valid) begin
                mem_readdatavalid = 1'b1;
                mem_readdata      = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
                mem_response      = err.exists(pend_addr) ? 2'd2 : 2'd0;
                pend = 1'b0;
            end
            if (mem_read) begin
                if (stall_req > 0) begin
                    mem_waitrequest = 1'b1;
                    stall_req--;
                end else if (rand_wait) mem_waitrequest = ($urandom_range(0, 3) == 0);
                else mem_waitrequest = 1'b0;
                if (mem_waitrequest) stalls++;
                else begin
                    pend = 1'b1; pend_addr = mem_address; reads++;
                end
            end else begin
                mem_waitrequest = 1'($urandom_range(0, 1));
            end
        end
    end

    logic [21:0] last_ppn;
    logic [7:0]  last_meta;

    task automatic run_walk(input logic [21:0] satp, input logic [19:0] vpn,
                            input int stall, input bit poke);
        bit          e_pf, e_af, got, prev_rd;
        logic [21:0] e_ppn;
        logic [7:0]  e_meta;
        logic [33:0] prev_addr;
        int          e_reads, lat;
        ref_walk(satp, vpn, e_pf, e_af, e_ppn, e_meta, e_reads);
        reads = 0; stalls = 0; stall_req = stall;
        @(negedge clk);
        resolve_request = 1'b1;
        resolve_virtual_address = vpn;
        satp_ppn = satp;
        #1 check("ack", 64'(resolve_ack), 64'd1);
        @(posedge clk);
        #1 resolve_request = 1'b0;
        resolve_virtual_address = $urandom;
        satp_ppn = $urandom;
        lat = 0; got = 0; prev_rd = 0; prev_addr = '0;
        while (lat < 200 && !got) begin
            @(negedge clk);
            lat++;
            if (poke && lat <= 3) begin
                resolve_request = 1'b1;
                #1 check("ack_busy", 64'(resolve_ack), 64'd0);
                resolve_request = 1'b0;
            end
            if (mem_read && prev_rd) check("addr_stable", 64'(mem_address), 64'(prev_addr));
            prev_rd = mem_read;
            prev_addr = mem_address;
            if (resolve_done) got = 1;
        end
        check("done_seen", 64'(got), 64'd1);
        check("latency", 64'(lat), 64'(1 + 2 * e_reads + stalls));
        check("reads", 64'(reads), 64'(e_reads));
        check("pagefault", 64'(resolve_pagefault), 64'(e_pf));
        check("accessfault", 64'(resolve_accessfault), 64'(e_af));
        if (!e_pf && !e_af) begin
            check("ppn", 64'(resolve_physical_address), 64'(e_ppn));
            check("meta", 64'(resolve_metadata), 64'(e_meta));
        end
        last_ppn = resolve_physical_address;
        last_meta = resolve_metadata;
        @(negedge clk);
        check("done_pulse", 64'(resolve_done), 64'd0);
    endtask

    task automatic map_4k;
        mem.delete(); err.delete();
        mem[34'h1400] = 32'h00000801;
        mem[34'h248C] = 32'h012345C7;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [21:0] satp;
        logic [19:0] vpn;
        logic [21:0] l0ppn;
        logic [31:0] rnd;
        logic [33:0] a1, a0;
        int          kind;

        rst = 1'b1;
        resolve_request = 1'b0;
        resolve_virtual_address = '0;
        satp_ppn = '0;
        repeat (2) @(negedge clk);
        check("rst_done", 64'(resolve_done), 64'd0);
        check("rst_ack", 64'(resolve_ack), 64'd0);
        check("rst_read", 64'(mem_read), 64'd0);
        check("rst_addr", 64'(mem_address), 64'd0);
        check("rst_ppn", 64'(resolve_physical_address), 64'd0);
        check("rst_meta", 64'(resolve_metadata), 64'd0);
        check("rst_faults", 64'({resolve_pagefault, resolve_accessfault}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Superpage
        mem.delete(); err.delete();
        mem[34'h1400] = 32'h200000CF;
        run_walk(22'h00001, 20'h40123, 0, 0);
        check("sp_ppn_const", 64'(last_ppn), 64'h080123);
        check("sp_meta_const", 64'(last_meta), 64'hCF);

        // 4 KiB page
        map_4k();
        run_walk(22'h00001, 20'h40123, 0, 0);
        check("4k_ppn_const", 64'(last_ppn), 64'h0048D1);
        check("4k_meta_const", 64'(last_meta), 64'hC7);

        // Faults
        mem.delete(); mem[34'h1400] = 32'h00000000;
        run_walk(22'h00001, 20'h40123, 0, 0);
        mem[34'h1400] = 32'h00000005;
        run_walk(22'h00001, 20'h40123, 0, 0);
        mem[34'h1400] = 32'h00000C0F;
        run_walk(22'h00001, 20'h40123, 0, 0);
        map_4k(); mem[34'h248C] = 32'h00000801;
        run_walk(22'h00001, 20'h40123, 0, 0);
        map_4k(); err[34'h248C] = 1'b1;
        run_walk(22'h00001, 20'h40123, 0, 0);

        // Stalled accept with a request poked during the walk
        map_4k();
        run_walk(22'h00001, 20'h40123, 5, 1);

        // Reset while waiting for read data
        map_4k();
        hold_valid = 1'b1; reads = 0; stall_req = 0;
        @(negedge clk);
        resolve_request = 1'b1;
        resolve_virtual_address = 20'h40123;
        satp_ppn = 22'h00001;
        @(posedge clk);
        #1 resolve_request = 1'b0;
        for (int i = 0; i < 20 && reads == 0; i++) @(negedge clk);
        check("rst_reach_wait", 64'(reads), 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("mid_rst_read", 64'(mem_read), 64'd0);
        check("mid_rst_outs", 64'({resolve_done, resolve_pagefault, resolve_accessfault,
                                   resolve_ack}), 64'd0);
        check("mid_rst_ppn", 64'(resolve_physical_address), 64'd0);
        check("mid_rst_meta", 64'(resolve_metadata), 64'd0);
        check("mid_rst_addr", 64'(mem_address), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        hold_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stray_done", 64'(resolve_done), 64'd0);
            check("stray_read", 64'(mem_read), 64'd0);
        end
        run_walk(22'h00001, 20'h40123, 0, 0);

        // Randomized tables with random wait states
        rand_wait = 1'b1;
        for (int it = 0; it < 40; it++) begin
            mem.delete(); err.delete();
            satp = 22'($urandom);
            vpn = 20'($urandom);
            l0ppn = 22'($urandom);
            rnd = $urandom;
            kind = $urandom_range(0, 5);
            a1 = {satp, 12'h000} + 34'(vpn[19:10]) * 34'd4;
            a0 = 34'(l0ppn) * 34'd4096 + 34'(vpn[9:0]) * 34'd4;
            case (kind)
                0: mem[a1] = rnd;
                1: mem[a1] = {rnd[31:20], 10'h000, rnd[9:2], 2'b11};
                2: begin mem[a1] = {l0ppn, 10'h001}; mem[a0] = {rnd[31:2], 2'b11}; end
                3: begin mem[a1] = {l0ppn, 10'h001}; mem[a0] = rnd; end
                4: begin mem[a1] = {l0ppn, 10'h001}; mem[a0] = rnd; err[a0] = 1'b1; end
                default: begin mem[a1] = rnd; err[a1] = 1'b1; end
            endcase
            run_walk(satp, vpn, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
